cache_arbiter: RTL and testbench

Shares the single physical-memory path (cacheline adaptor) of `mp3` between the instruction cache and the data cache. The arbiter accepts one cache-line transaction at a time, with round-robin priority on contention. It forwards the transaction to the adaptor and returns the response only to the granted cache. It sits between `i_cache`/`d_cache` and the cacheline adaptor inside `mp3`.

---
 rtl/cache_arbiter.sv | 110 +++++++++++
 tb/tb_cache_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline adaptor between the I-cache and D-cache.
// One line transaction at a time; a RELEASE cycle follows each response so stale request levels are never regranted.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  a_read,
  output logic                  a_write,
  output logic [ADDR_WIDTH-1:0] a_address,
  output logic [LINE_WIDTH-1:0] a_wdata,
  input  logic [LINE_WIDTH-1:0] a_rdata,
  input  logic                  a_resp
);

  // state   | meaning
  // IDLE    | no transaction; arbitrate between pending requests
  // SERVE_I | adaptor busy with an I-cache line read
  // SERVE_D | adaptor busy with a D-cache read or write-back
  // RELEASE | dead cycle so the served cache can drop its request
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t                state, state_next;
  logic                  last, last_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  wr_q;
  logic                  i_req, d_req;
  logic                  grant_i, grant_d;

  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign a_address = addr_q;
  assign a_wdata   = wdata_q;
  assign i_rdata   = a_rdata;
  assign d_rdata   = a_rdata;

  always_comb begin
    state_next = state;
    last_next  = last;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    a_read     = 1'b0;
    a_write    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, last == 1 (D served last) hands the grant to I.
        if (i_req && (!d_req || last)) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end
      end
      SERVE_I: begin
        a_read = 1'b1;
        if (a_resp) begin
          i_resp     = 1'b1;
          last_next  = 1'b0;
          state_next = RELEASE;
        end
      end
      SERVE_D: begin
        a_write = wr_q;
        a_read  = ~wr_q;
        if (a_resp) begin
          d_resp     = 1'b1;
          last_next  = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_next;
      last  <= last_next;
      if (grant_i) addr_q <= i_address;
      if (grant_d) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        wr_q    <= d_write;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, a_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, a_rdata;
  logic [LW-1:0] i_rdata, d_rdata, a_wdata;
  logic          i_resp, d_resp, a_read, a_write;
  logic [AW-1:0] a_address;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_resp(a_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Transaction-level reference: who owns the adaptor, and whether we are in the post-response gap.
  int            m_own = 0;   // 0 none, 1 I-cache, 2 D-cache
  bit            m_gap = 0;
  bit            m_last_d = 1;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  bit            m_wr = 0;
  int            m_who;
  bit            checking = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_own = 0; m_gap = 0; m_last_d = 1; m_addr = '0; m_wdata = '0; m_wr = 0;
    end else if (m_own != 0) begin
      if (a_resp) begin
        m_last_d = (m_own == 2);
        m_own = 0;
        m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      m_who = 0;
      if (i_read && (d_read || d_write)) m_who = m_last_d ? 1 : 2;
      else if (i_read) m_who = 1;
      else if (d_read || d_write) m_who = 2;
      if (m_who == 1) m_addr = i_address;
      if (m_who == 2) begin
        m_addr = d_address; m_wdata = d_wdata; m_wr = d_write;
      end
      m_own = m_who;
    end
  end

  int grant_log[$];
  int i_cnt = 0;
  int d_cnt = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("a_read",    a_read,    (m_own == 1) || (m_own == 2 && !m_wr));
      chk("a_write",   a_write,   m_own == 2 && m_wr);
      chk("i_resp",    i_resp,    m_own == 1 && a_resp);
      chk("d_resp",    d_resp,    m_own == 2 && a_resp);
      chk("a_address", a_address, m_addr);
      chk("i_rdata",   i_rdata,   a_rdata);
      chk("d_rdata",   d_rdata,   a_rdata);
      if (m_own == 2) chk("a_wdata", a_wdata, m_wdata);
      if (i_resp) begin grant_log.push_back(0); i_cnt++; end
      if (d_resp) begin grant_log.push_back(1); d_cnt++; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  bit i_done = 0;
  bit d_done = 0;

  // One cycle of randomized cache and adaptor behaviour; called right after tick().
  task automatic auto_cycle(input int p_req, input int p_drop, input int p_resp, input int p_spur);
    a_resp = 1'b0;
    if (i_done) begin
      i_read = 1'b0; i_done = 0;
    end else if (!i_read && $urandom_range(0, 99) < p_req) begin
      i_read = 1'b1; i_address = $urandom & 32'hFFFF_FFE0;
    end else if (i_read && $urandom_range(0, 99) < p_drop) begin
      i_read = 1'b0;
    end
    if (d_done) begin
      d_read = 1'b0; d_write = 1'b0; d_done = 0;
    end else if (!(d_read || d_write) && $urandom_range(0, 99) < p_req) begin
      d_write = $urandom_range(0, 1);
      d_read = !d_write;
      d_address = $urandom & 32'hFFFF_FFE0;
      d_wdata = rand_line();
    end else if ((d_read || d_write) && $urandom_range(0, 99) < p_drop) begin
      d_read = 1'b0; d_write = 1'b0;
    end
    if (a_read || a_write) a_resp = ($urandom_range(0, 99) < p_resp);
    else a_resp = ($urandom_range(0, 99) < p_spur);
    a_rdata = rand_line();
    #1;
    if (i_resp) i_done = 1;
    if (d_resp) d_done = 1;
  endtask

  task automatic drain();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_done = 0; d_done = 0;
    repeat (20) begin
      tick();
      a_resp = (a_read || a_write) && !a_resp;
    end
    tick();
    a_resp = 1'b0;
    tick();
  endtask

  int ic0, dc0, base, k;

  initial begin
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; a_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; a_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    checking = 1;
    chk("rst_a_read", a_read, 0);
    chk("rst_a_write", a_write, 0);
    chk("rst_a_address", a_address, 0);
    chk("rst_a_wdata", a_wdata, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);

    // I read alone
    ic0 = i_cnt; dc0 = d_cnt;
    i_read = 1'b1; i_address = 32'h0000_0060;
    tick();
    chk("t1_a_read_latency", a_read, 1);
    chk("t1_a_address", a_address, 32'h60);
    repeat (5) tick();
    a_resp = 1'b1; a_rdata = {8{32'hDEADBEEF}};
    #1;
    chk("t1_i_resp", i_resp, 1);
    chk("t1_i_rdata", i_rdata, {8{32'hDEADBEEF}});
    chk("t1_d_resp", d_resp, 0);
    tick();
    a_resp = 1'b0; i_read = 1'b0;
    #1;
    chk("t1_release_a_read", a_read, 0);
    chk("t1_i_resp_single", i_resp, 0);
    tick(); tick();
    chk("t1_i_pulses", i_cnt - ic0, 1);
    chk("t1_d_pulses", d_cnt - dc0, 0);

    // D write-back
    dc0 = d_cnt;
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = {8{32'h12345678}};
    tick();
    chk("t2_a_write", a_write, 1);
    chk("t2_a_read", a_read, 0);
    chk("t2_a_wdata", a_wdata, {8{32'h12345678}});
    chk("t2_a_address", a_address, 32'h1000);
    repeat (2) tick();
    a_resp = 1'b1;
    #1;
    chk("t2_d_resp", d_resp, 1);
    chk("t2_i_resp", i_resp, 0);
    tick();
    a_resp = 1'b0; d_write = 1'b0;
    tick(); tick();
    chk("t2_d_pulses", d_cnt - dc0, 1);

    // Simultaneous from reset: I first, D after the release gap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_read = 1'b1; d_read = 1'b1; i_address = 32'h200; d_address = 32'h300;
    tick();
    chk("t3_first_grant_i", a_read, 1);
    chk("t3_first_addr", a_address, 32'h200);
    tick();
    a_resp = 1'b1;
    #1;
    chk("t3_i_resp", i_resp, 1);
    chk("t3_no_d_resp", d_resp, 0);
    tick();
    a_resp = 1'b0; i_read = 1'b0;
    #1;
    chk("t3_release_gap", a_read, 0);
    tick();
    chk("t3_idle_gap", a_read, 0);
    tick();
    chk("t3_d_granted", a_read, 1);
    chk("t3_d_addr", a_address, 32'h300);
    a_resp = 1'b1;
    #1;
    chk("t3_d_resp", d_resp, 1);
    tick();
    a_resp = 1'b0; d_read = 1'b0;
    tick(); tick();

    // Fairness with two continuous contenders (D served last, so I leads)
    base = grant_log.size();
    k = 0;
    while (grant_log.size() < base + 6 && k < 400) begin
      tick();
      auto_cycle(100, 0, 40, 0);
      k++;
    end
    if (grant_log.size() < base + 6) timeout("t4_fairness");
    else for (int j = 0; j < 6; j++) chk($sformatf("t4_grant_%0d", j), grant_log[base + j], j % 2);
    drain();

    // Reset during SERVE_D with I pending
    d_read = 1'b1; d_address = 32'h400;
    tick();
    i_read = 1'b1; i_address = 32'h500;
    #1;
    chk("t5_serving_d", a_read, 1);
    chk("t5_d_addr", a_address, 32'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_a_read_dropped", a_read, 0);
    chk("t5_a_write_dropped", a_write, 0);
    chk("t5_d_resp_low", d_resp, 0);
    tick();
    chk("t5_i_granted", a_read, 1);
    chk("t5_i_addr", a_address, 32'h500);
    a_resp = 1'b1;
    #1;
    chk("t5_i_resp", i_resp, 1);
    tick();
    a_resp = 1'b0; i_read = 1'b0;
    drain();

    // Spurious a_resp in IDLE, then a request dropped mid-service
    ic0 = i_cnt; dc0 = d_cnt;
    a_resp = 1'b1;
    #1;
    chk("t6_spur_i_resp", i_resp, 0);
    chk("t6_spur_d_resp", d_resp, 0);
    tick();
    a_resp = 1'b0;
    chk("t6_spur_still_idle", a_read, 0);
    i_read = 1'b1; i_address = 32'h600;
    tick();
    chk("t6_granted", a_read, 1);
    i_read = 1'b0;
    tick();
    chk("t6_held_after_drop", a_read, 1);
    tick();
    a_resp = 1'b1;
    #1;
    chk("t6_i_resp", i_resp, 1);
    tick();
    a_resp = 1'b0;
    repeat (3) tick();
    chk("t6_no_regrant", a_read, 0);
    chk("t6_i_pulses", i_cnt - ic0, 1);
    chk("t6_d_pulses", d_cnt - dc0, 0);

    // Randomized traffic with drops, spurious responses and occasional reset
    repeat (3000) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      auto_cycle(30, 3, 30, 10);
    end
    rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
